adc_window_avg: RTL and testbench

Window averager that sits directly upstream of the 12-bit threshold comparator in the morphing-wing peripheral. It accepts raw 12-bit ADC samples over a valid/ready handshake and sums a fixed window of 2^LOG2_N samples. It then publishes the rounded mean as a held 12-bit register, which drives the comparator's `in0` operand. The comparator therefore sees a value that changes only once per window.

---
 rtl/morphing_wing_pkg.sv | 13 +
 rtl/adc_window_avg_if.sv | 22 ++
 rtl/adc_window_avg.sv | 94 +++++++++
 tb/tb_adc_window_avg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/morphing_wing_pkg.sv
// Shared types and constants for the morphing-wing peripheral.
// Used by the window averager and its comparator neighbour.
package morphing_wing_pkg;

  localparam int ADC_W = 12;
  localparam int AVG_LOG2_N_MAX = 4;

  typedef enum logic {
    ACC = 1'b0,
    PUB = 1'b1
  } avg_state_t;

endpackage

// File: rtl/adc_window_avg_if.sv
// Valid/ready sample stream carrying raw ADC codes.
// The source drives valid/data and the sink drives ready.
interface adc_window_avg_if;
  import morphing_wing_pkg::*;

  logic             in_valid;
  logic [ADC_W-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/adc_window_avg.sv
// Sums 2^LOG2_N accepted samples, then publishes the rounded mean.
// The mean is held until the next window completes.
module adc_window_avg
  import morphing_wing_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  adc_window_avg_if.slave   s,
  output logic [ADC_W-1:0]  out_data,
  output logic              out_valid,
  output logic              primed
);

  localparam int AW = ADC_W + LOG2_N;
  localparam int CW = LOG2_N + 1;
  localparam int N  = 1 << LOG2_N;
  // Half an LSB of the mean; zero for a window of one.
  localparam logic [AW:0] RND = (AW+1)'((1 << LOG2_N) >> 1);

  function automatic logic [ADC_W-1:0] round_mean(
    input logic [AW-1:0] a
  );
    logic [AW:0] t;
    t = {1'b0, a} + RND;
    return t[LOG2_N +: ADC_W];
  endfunction

  avg_state_t       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ADC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             primed_q, primed_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    primed_d    = primed_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (s.in_valid) begin
            acc_d = acc_q + AW'(s.in_data);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = PUB;
          end
        end
        PUB: begin
          out_data_d  = round_mean(acc_q);
          out_valid_d = 1'b1;
          primed_d    = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ACC;
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  assign s.in_ready = (state_q == ACC);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_adc_window_avg.sv
// Directed bench for adc_window_avg at LOG2_N=3 and LOG2_N=0.
// Window vectors are table-driven; corner cases are hand sequences.
module tb_adc_window_avg;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  adc_window_avg_if if3 ();
  adc_window_avg_if if0 ();

  logic [11:0] od3, od0;
  logic        ov3, ov0, pr3, pr0;

  adc_window_avg #(.LOG2_N(3)) d3 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s         (if3.slave),
    .out_data  (od3),
    .out_valid (ov3),
    .primed    (pr3)
  );

  adc_window_avg #(.LOG2_N(0)) d0 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s         (if0.slave),
    .out_data  (od0),
    .out_valid (ov0),
    .primed    (pr0)
  );

  typedef struct {
    logic [7:0][11:0] smp;
    logic [11:0]      exp;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_win(input string nm, input vec_t v);
    for (int i = 0; i < 8; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = v.smp[i];
      tick();
    end
    if3.in_valid = 1'b0;
    chk({nm, "_pub_rdy"}, 32'(if3.in_ready), 0);
    chk({nm, "_pub_ov"}, 32'(ov3), 0);
    tick();
    chk({nm, "_ov"}, 32'(ov3), 1);
    chk({nm, "_data"}, 32'(od3), 32'(v.exp));
    chk({nm, "_primed"}, 32'(pr3), 1);
    chk({nm, "_rdy_back"}, 32'(if3.in_ready), 1);
    tick();
    chk({nm, "_ov_drop"}, 32'(ov3), 0);
  endtask

  function automatic vec_t flat(input logic [11:0] val);
    vec_t v;
    for (int i = 0; i < 8; i++) v.smp[i] = val;
    v.exp = val;
    return v;
  endfunction

  vec_t tbl[6];
  vec_t w;
  logic [11:0] bp_smp[16];
  logic [11:0] bp_mean[2];
  int          bp_idx;
  int          bp_pubs;
  logic        rdy;

  initial begin
    tbl[0] = flat(12'd100);
    for (int i = 0; i < 8; i++) tbl[1].smp[i] = 12'(i);
    tbl[1].exp = 12'd4;
    tbl[2].smp = '0;
    tbl[2].smp[7] = 12'd3;
    tbl[2].exp = 12'd0;
    tbl[3].smp = '0;
    tbl[3].smp[7] = 12'd4;
    tbl[3].exp = 12'd1;
    tbl[4] = flat(12'd4095);
    for (int i = 0; i < 8; i++) tbl[5].smp[i] = 12'(10 * (i + 1));
    tbl[5].exp = 12'd45;

    rst = 1'b1;
    clr = 1'b0;
    if3.in_valid = 1'b0;
    if3.in_data  = '0;
    if0.in_valid = 1'b0;
    if0.in_data  = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_od", 32'(od3), 0);
    chk("rst_ov", 32'(ov3), 0);
    chk("rst_primed", 32'(pr3), 0);
    chk("rst_rdy", 32'(if3.in_ready), 1);
    chk("rst_rdy0", 32'(if0.in_ready), 1);

    // window of one: publish one cycle after acceptance
    if0.in_valid = 1'b1;
    if0.in_data  = 12'd2048;
    tick();
    if0.in_valid = 1'b0;
    chk("n1_rdy", 32'(if0.in_ready), 0);
    chk("n1_ov_early", 32'(ov0), 0);
    tick();
    chk("n1_ov", 32'(ov0), 1);
    chk("n1_data", 32'(od0), 2048);
    chk("n1_primed", 32'(pr0), 1);
    tick();
    chk("n1_ov_drop", 32'(ov0), 0);

    for (int k = 0; k < 6; k++)
      run_win($sformatf("vec%0d", k), tbl[k]);

    // valid held high straight through the dead PUB cycle
    for (int i = 0; i < 8; i++) bp_smp[i] = 12'(100 * i);
    for (int i = 0; i < 8; i++) bp_smp[8 + i] = 12'(i + 1);
    bp_idx  = 0;
    bp_pubs = 0;
    for (int c = 0; c < 22; c++) begin
      if3.in_valid = (bp_idx < 16);
      if3.in_data  = (bp_idx < 16) ? bp_smp[bp_idx] : 12'd0;
      rdy = if3.in_ready;
      tick();
      if (rdy && bp_idx < 16) bp_idx++;
      if (ov3) begin
        if (bp_pubs < 2) bp_mean[bp_pubs] = od3;
        bp_pubs++;
      end
    end
    if3.in_valid = 1'b0;
    chk("bp_taken", 32'(bp_idx), 16);
    chk("bp_pubs", 32'(bp_pubs), 2);
    chk("bp_mean0", 32'(bp_mean[0]), 350);
    chk("bp_mean1", 32'(bp_mean[1]), 5);

    // clr discards a partial window
    for (int i = 0; i < 5; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 12'd500;
      tick();
    end
    if3.in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ov", 32'(ov3), 0);
    chk("clr_od_hold", 32'(od3), 5);
    chk("clr_primed", 32'(pr3), 1);
    run_win("after_clr", flat(12'd200));

    // clr coincident with the eighth sample
    for (int i = 0; i < 8; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 12'd600;
      clr = (i == 7);
      tick();
    end
    clr = 1'b0;
    if3.in_valid = 1'b0;
    chk("clr8_rdy", 32'(if3.in_ready), 1);
    chk("clr8_cnt", 32'(d3.cnt_q), 0);
    chk("clr8_acc", 32'(d3.acc_q), 0);
    tick();
    chk("clr8_ov", 32'(ov3), 0);
    chk("clr8_od", 32'(od3), 200);
    run_win("after_clr8", flat(12'd40));

    // clr during PUB cancels the publish
    for (int i = 0; i < 8; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 12'd1000;
      tick();
    end
    if3.in_valid = 1'b0;
    chk("clrpub_rdy", 32'(if3.in_ready), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrpub_ov", 32'(ov3), 0);
    chk("clrpub_od", 32'(od3), 40);
    chk("clrpub_rdy_back", 32'(if3.in_ready), 1);
    tick();
    chk("clrpub_ov2", 32'(ov3), 0);

    // reset in mid-window
    for (int i = 0; i < 3; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 12'd700;
      tick();
    end
    if3.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_od", 32'(od3), 0);
    chk("mrst_ov", 32'(ov3), 0);
    chk("mrst_primed", 32'(pr3), 0);
    chk("mrst_rdy", 32'(if3.in_ready), 1);
    chk("mrst_acc", 32'(d3.acc_q), 0);
    run_win("after_rst", flat(12'd300));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
